// File: rtl/mem_arb_2p.sv
// Two-port round-robin arbiter in front of a 1r1w word memory, with a 1-cycle response path per port.
// Optional MEM_ARB_STATS_EN adds saturating per-port grant counters.
module mem_arb_2p #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH) + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    input  logic             r0_we,
    input  logic [AW-1:0]    r0_addr,
    input  logic [WIDTH-1:0] r0_wdata,
    output logic             r0_ready,
    output logic             r0_rvalid,
    output logic [WIDTH-1:0] r0_rdata,
    output logic             r0_err,
    input  logic             r1_valid,
    input  logic             r1_we,
    input  logic [AW-1:0]    r1_addr,
    input  logic [WIDTH-1:0] r1_wdata,
    output logic             r1_ready,
    output logic             r1_rvalid,
    output logic [WIDTH-1:0] r1_rdata,
    output logic             r1_err,
    output logic [AW-1:0]    mem_rd_addr,
    output logic [AW-1:0]    mem_wr_addr,
    output logic [WIDTH-1:0] mem_wr_din,
    output logic             mem_we,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]      r0_grants,
    output logic [15:0]      r1_grants,
`endif
    input  logic [WIDTH-1:0] mem_rd_dout
);

    typedef enum logic {IDLE, RESP} resp_state_t;

    resp_state_t r0_state, r0_state_next;
    resp_state_t r1_state, r1_state_next;
    logic        last_grant;
    logic        r0_err_q, r1_err_q;
    logic        grant0, grant1;
    logic        mis0, mis1;

    // last_grant: 0 means r0 was granted last, 1 means r1; a tie goes to the other one
    assign grant0 = r0_valid & (~r1_valid | last_grant);
    assign grant1 = r1_valid & (~r0_valid | ~last_grant);
    assign mis0   = |r0_addr[1:0];
    assign mis1   = |r1_addr[1:0];

    always_comb begin
        r0_ready      = grant0;
        r1_ready      = grant1;
        mem_rd_addr   = '0;
        mem_wr_addr   = '0;
        mem_wr_din    = '0;
        r0_state_next = grant0 ? RESP : IDLE;
        r1_state_next = grant1 ? RESP : IDLE;
        if (grant0) begin
            mem_rd_addr = r0_addr;
            mem_wr_addr = r0_addr;
            mem_wr_din  = r0_wdata;
        end else if (grant1) begin
            mem_rd_addr = r1_addr;
            mem_wr_addr = r1_addr;
            mem_wr_din  = r1_wdata;
        end
        // Gated by rst so no write can leak out while reset is held
        mem_we    = rst & ((grant0 & r0_we & ~mis0) | (grant1 & r1_we & ~mis1));
        r0_rvalid = (r0_state == RESP);
        r1_rvalid = (r1_state == RESP);
        r0_err    = r0_rvalid & r0_err_q;
        r1_err    = r1_rvalid & r1_err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0_state   <= IDLE;
            r1_state   <= IDLE;
            last_grant <= 1'b1;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            r0_state <= r0_state_next;
            r1_state <= r1_state_next;
            if (grant0) begin
                last_grant <= 1'b0;
                r0_err_q   <= mis0;
                if (!r0_we && !mis0) r0_rdata <= mem_rd_dout;
            end
            if (grant1) begin
                last_grant <= 1'b1;
                r1_err_q   <= mis1;
                if (!r1_we && !mis1) r1_rdata <= mem_rd_dout;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0_grants <= '0;
            r1_grants <= '0;
        end else begin
            if (grant0 && r0_grants != 16'hFFFF) r0_grants <= r0_grants + 16'd1;
            if (grant1 && r1_grants != 16'hFFFF) r1_grants <= r1_grants + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arb_2p.sv
// Directed self-checking bench for mem_arb_2p with a small behavioural 1r1w memory.
// Stats checks are compiled in only when MEM_ARB_STATS_EN is defined.
module tb_mem_arb_2p;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 4;

    logic             clk;
    logic             rst;
    logic             r0_valid, r0_we, r1_valid, r1_we;
    logic [AW-1:0]    r0_addr, r1_addr;
    logic [WIDTH-1:0] r0_wdata, r1_wdata;
    logic             r0_ready, r0_rvalid, r0_err;
    logic             r1_ready, r1_rvalid, r1_err;
    logic [WIDTH-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0]    mem_rd_addr, mem_wr_addr;
    logic [WIDTH-1:0] mem_wr_din, mem_rd_dout;
    logic             mem_we;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]      r0_grants, r1_grants;
`endif

    logic [WIDTH-1:0] mem_model [DEPTH];
    int total = 0;
    int bad   = 0;

    mem_arb_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
        .mem_we(mem_we),
`ifdef MEM_ARB_STATS_EN
        .r0_grants(r0_grants), .r1_grants(r1_grants),
`endif
        .mem_rd_dout(mem_rd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_dout = mem_model[mem_rd_addr[AW-1:2]];
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_wr_addr[AW-1:2]] <= mem_wr_din;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic we0, input logic [AW-1:0] a0,
                                 input logic [WIDTH-1:0] d0, input logic v1, input logic we1,
                                 input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
        r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        // A pending aligned write while in reset must not reach the memory
        applyStimulus(1'b1, 1'b1, 4'h0, 32'h11111111, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_r0_rvalid", r0_rvalid, 0);
        checkOutput("rst_r1_rvalid", r1_rvalid, 0);
        checkOutput("rst_r0_rdata", r0_rdata, 0);
        checkOutput("rst_r1_rdata", r1_rdata, 0);
        checkOutput("rst_r0_err", r0_err, 0);
        @(negedge clk);
        idleInputs();
        rst = 1'b1;

        // r0 aligned write of 0xDEADBEEF to 0x4
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'h4, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("wr_r0_ready", r0_ready, 1);
        checkOutput("wr_r1_ready", r1_ready, 0);
        checkOutput("wr_mem_we", mem_we, 1);
        checkOutput("wr_mem_wr_addr", mem_wr_addr, 4'h4);
        checkOutput("wr_mem_wr_din", mem_wr_din, 32'hDEADBEEF);
        @(posedge clk); #1;
        checkOutput("wr_r0_rvalid", r0_rvalid, 1);
        checkOutput("wr_r0_err", r0_err, 0);
        checkOutput("wr_r0_rdata_kept", r0_rdata, 0);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("idle_mem_rd_addr", mem_rd_addr, 0);
        @(posedge clk); #1;
        checkOutput("wr_r0_rvalid_drop", r0_rvalid, 0);

        // r1 reads back 0x4
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0 | 1'b1, 1'b0, 4'h4, '0);
        #1;
        checkOutput("rd_r1_ready", r1_ready, 1);
        checkOutput("rd_mem_rd_addr", mem_rd_addr, 4'h4);
        checkOutput("rd_mem_we", mem_we, 0);
        @(posedge clk); #1;
        checkOutput("rd_r1_rvalid", r1_rvalid, 1);
        checkOutput("rd_r1_rdata", r1_rdata, 32'hDEADBEEF);
        checkOutput("rd_r1_err", r1_err, 0);

        // Both requesting right after reset: r0, r1, r0, r1
        doReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 4'h4, '0, 1'b1, 1'b0, 4'h4, '0);
            #1;
            checkOutput($sformatf("rr_r0_ready_%0d", i), r0_ready, (i % 2 == 0));
            checkOutput($sformatf("rr_r1_ready_%0d", i), r1_ready, (i % 2 == 1));
            @(posedge clk); #1;
            checkOutput($sformatf("rr_r0_rvalid_%0d", i), r0_rvalid, (i % 2 == 0));
            checkOutput($sformatf("rr_r1_rvalid_%0d", i), r1_rvalid, (i % 2 == 1));
        end
        checkOutput("rr_r0_rdata", r0_rdata, 32'hDEADBEEF);
        checkOutput("rr_r1_rdata", r1_rdata, 32'hDEADBEEF);
`ifdef MEM_ARB_STATS_EN
        checkOutput("rr_r0_grants", r0_grants, 2);
        checkOutput("rr_r1_grants", r1_grants, 2);
`endif

        // Misaligned write to 0x6 must leave word 1 untouched
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'h6, 32'h12345678, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("mis_r0_ready", r0_ready, 1);
        checkOutput("mis_mem_we", mem_we, 0);
        @(posedge clk); #1;
        checkOutput("mis_r0_rvalid", r0_rvalid, 1);
        checkOutput("mis_r0_err", r0_err, 1);
        checkOutput("mis_r0_rdata_kept", r0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        idleInputs();
        @(posedge clk); #1;
        checkOutput("mis_r0_err_clear", r0_err, 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'h4, '0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        checkOutput("mis_readback", r0_rdata, 32'hDEADBEEF);

        // r1 writes 0x8, misaligned read of 0x9 keeps old rdata, aligned read returns new word
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'h8, 32'hCAFEF00D);
        #1;
        checkOutput("w8_mem_we", mem_we, 1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'h9, '0);
        @(posedge clk); #1;
        checkOutput("mr9_r1_err", r1_err, 1);
        checkOutput("mr9_r1_rdata_kept", r1_rdata, 32'hDEADBEEF);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'h8, '0);
        @(posedge clk); #1;
        checkOutput("r8_r1_rdata", r1_rdata, 32'hCAFEF00D);
        checkOutput("r8_r1_err", r1_err, 0);

        // Back-to-back r0 reads: responses on consecutive cycles
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'h8, '0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        checkOutput("b2b_rvalid_0", r0_rvalid, 1);
        checkOutput("b2b_rdata_0", r0_rdata, 32'hCAFEF00D);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'h4, '0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        checkOutput("b2b_rvalid_1", r0_rvalid, 1);
        checkOutput("b2b_rdata_1", r0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        idleInputs();
        @(posedge clk); #1;
        checkOutput("b2b_rvalid_end", r0_rvalid, 0);

        // Reset right after an accepted read drops the response
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'h8, '0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_rvalid", r0_rvalid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_rvalid", r0_rvalid, 0);
        checkOutput("post_rst_rdata", r0_rdata, 0);
        @(posedge clk); #1;
        checkOutput("post_rst_rvalid_2", r0_rvalid, 0);
`ifdef MEM_ARB_STATS_EN
        checkOutput("post_rst_r0_grants", r0_grants, 0);
        checkOutput("post_rst_r1_grants", r1_grants, 0);

        // Saturation of the r0 counter
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'h4, '0, 1'b0, 1'b0, '0, '0);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("sat_r0_grants", r0_grants, 16'hFFFF);
        checkOutput("sat_r1_grants", r1_grants, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
